pipe_mips32: RTL and testbench

- Five-stage in-order pipelined MIPS32-subset core: IF, ID, EX, MEM, WB.
- One unified word-addressed instruction/data memory and a 32x32 register file, both held inside the block.
- Top-level compute block for bring-up and regression; programs are preloaded through hierarchical access to the Mem and Reg arrays.
- Runs until a HLT instruction retires, then freezes.

---
 rtl/pipe_mips32_pkg.sv | 79 +++++++
 rtl/pipe_mips32_alu.sv | 25 ++
 rtl/pipe_mips32.sv | 171 +++++++++++++++++
 tb/tb_pipe_mips32.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mips32_pkg.sv
// Shared opcodes, instruction classes and pipeline-register layouts for pipe_mips32.
// MIPS32_MUL_EN selects whether MUL decodes as an RR-ALU op or as a NOP.
package pipe_mips32_pkg;

   localparam int PC_W_DEF = 10;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_AND   = 6'b000010;
   localparam logic [5:0] OP_OR    = 6'b000011;
   localparam logic [5:0] OP_SLT   = 6'b000100;
   localparam logic [5:0] OP_MUL   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b001000;
   localparam logic [5:0] OP_SW    = 6'b001001;
   localparam logic [5:0] OP_ADDI  = 6'b001010;
   localparam logic [5:0] OP_SUBI  = 6'b001011;
   localparam logic [5:0] OP_SLTI  = 6'b001100;
   localparam logic [5:0] OP_BNEQZ = 6'b001101;
   localparam logic [5:0] OP_BEQZ  = 6'b001110;
   localparam logic [5:0] OP_HLT   = 6'b111111;

   typedef enum logic [2:0] {
      RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP
   } itype_e;

   typedef struct packed {
      logic                valid;
      logic [31:0]         ir;
      logic [PC_W_DEF-1:0] npc;
   } IF_ID_t;

   typedef struct packed {
      logic                valid;
      itype_e              itype;
      logic [5:0]          op;
      logic [4:0]          rs;
      logic [4:0]          rt;
      logic [4:0]          dest;
      logic [31:0]         a;
      logic [31:0]         b;
      logic [31:0]         imm;
      logic [PC_W_DEF-1:0] npc;
   } ID_EX_t;

   typedef struct packed {
      logic        valid;
      itype_e      itype;
      logic [4:0]  dest;
      logic [31:0] alu_out;
      logic [31:0] b;
   } EX_MEM_t;

   typedef struct packed {
      logic        valid;
      itype_e      itype;
      logic [4:0]  dest;
      logic [31:0] result;
   } MEM_WB_t;

   function automatic itype_e decode_type(input logic [5:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: decode_type = RR_ALU;
`ifdef MIPS32_MUL_EN
         OP_MUL:                                decode_type = RR_ALU;
`endif
         OP_ADDI, OP_SUBI, OP_SLTI:             decode_type = RM_ALU;
         OP_LW:                                 decode_type = LOAD;
         OP_SW:                                 decode_type = STORE;
         OP_BNEQZ, OP_BEQZ:                     decode_type = BRANCH;
         OP_HLT:                                decode_type = HALT;
         default:                               decode_type = NOP;
      endcase
   endfunction

   function automatic logic writes_reg(input itype_e t);
      return t inside {RR_ALU, RM_ALU, LOAD};
   endfunction

endpackage

// File: rtl/pipe_mips32_alu.sv
// Combinational ALU: LW/SW/ADDI and unknown ops add; MUL exists only with MIPS32_MUL_EN.
module pipe_mips32_alu
   import pipe_mips32_pkg::*;
(
   input  logic [5:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] result_o
);

   always_comb begin
      result_o = a_i + b_i;
      case (op_i)
         OP_SUB, OP_SUBI: result_o = a_i - b_i;
         OP_AND:          result_o = a_i & b_i;
         OP_OR:           result_o = a_i | b_i;
         OP_SLT, OP_SLTI: result_o = {31'd0, $signed(a_i) < $signed(b_i)};
`ifdef MIPS32_MUL_EN
         OP_MUL:          result_o = $signed(a_i) * $signed(b_i);
`endif
         default:         result_o = a_i + b_i;
      endcase
   end

endmodule

// File: rtl/pipe_mips32.sv
// pipe_mips32: five-stage in-order MIPS32-subset core with unified word memory.
// Define MIPS32_MUL_EN to build the single-cycle MUL; PC_W must match PC_W_DEF.
module pipe_mips32
   import pipe_mips32_pkg::*;
#(
   parameter int MEM_DEPTH = 1024,
   parameter int PC_W      = PC_W_DEF
) (
   input  logic clock1,
   input  logic rst_n,
   output logic halted
);

   logic [31:0] Reg [0:31];
   logic [31:0] Mem [0:MEM_DEPTH-1];

   logic [PC_W-1:0] PC, pc_d, pc_inc;
   logic            HALTED, halted_d;
   logic            TAKEN_BRANCH;
   logic            fetch_stop_q, fetch_stop_d;

   IF_ID_t  if_id_q,  if_id_d;
   ID_EX_t  id_ex_q,  id_ex_d;
   EX_MEM_t ex_mem_q, ex_mem_d;
   MEM_WB_t mem_wb_q, mem_wb_d;

   logic [5:0]  id_op;
   logic [4:0]  id_rs, id_rt, id_rd;
   itype_e      id_type;
   logic [31:0] id_imm, id_a, id_b;
   logic        id_uses_rs, id_uses_rt, load_use, id_is_hlt;

   logic            em_fwd_ok, fwd_a_em, fwd_a_mw, fwd_b_em, fwd_b_mw;
   logic [31:0]     ex_a, ex_b, alu_b, alu_res;
   logic [PC_W-1:0] ex_target;

   logic        mem_we, wb_we;
   logic [31:0] mem_rdata;

   assign halted = HALTED;
   assign pc_inc = PC + PC_W'(1);

   // ---------------- ID: decode, write-through register read ----------------
   assign id_op   = if_id_q.ir[31:26];
   assign id_rs   = if_id_q.ir[25:21];
   assign id_rt   = if_id_q.ir[20:16];
   assign id_rd   = if_id_q.ir[15:11];
   assign id_imm  = {{16{if_id_q.ir[15]}}, if_id_q.ir[15:0]};
   assign id_type = decode_type(id_op);

   assign id_uses_rs = id_type inside {RR_ALU, RM_ALU, LOAD, STORE, BRANCH};
   assign id_uses_rt = id_type inside {RR_ALU, STORE};
   assign id_is_hlt  = if_id_q.valid && (id_type == HALT);

   always_comb begin
      id_a = Reg[id_rs];
      id_b = Reg[id_rt];
      if (wb_we && (mem_wb_q.dest == id_rs)) id_a = mem_wb_q.result;
      if (wb_we && (mem_wb_q.dest == id_rt)) id_b = mem_wb_q.result;
      if (id_rs == 5'd0) id_a = '0;
      if (id_rt == 5'd0) id_b = '0;
   end

   // A load's data is only ready in MEM/WB, so a consumer directly behind it waits one cycle.
   assign load_use = if_id_q.valid && id_ex_q.valid && (id_ex_q.itype == LOAD) &&
                     (id_ex_q.dest != 5'd0) &&
                     ((id_uses_rs && (id_rs == id_ex_q.dest)) ||
                      (id_uses_rt && (id_rt == id_ex_q.dest)));

   // ---------------- EX: forwarding, ALU, branch resolution ----------------
   assign em_fwd_ok = ex_mem_q.valid && (ex_mem_q.itype inside {RR_ALU, RM_ALU}) &&
                      (ex_mem_q.dest != 5'd0);
   assign fwd_a_em  = em_fwd_ok && (ex_mem_q.dest == id_ex_q.rs);
   assign fwd_b_em  = em_fwd_ok && (ex_mem_q.dest == id_ex_q.rt);
   assign fwd_a_mw  = wb_we && (mem_wb_q.dest == id_ex_q.rs);
   assign fwd_b_mw  = wb_we && (mem_wb_q.dest == id_ex_q.rt);

   assign ex_a  = fwd_a_em ? ex_mem_q.alu_out : (fwd_a_mw ? mem_wb_q.result : id_ex_q.a);
   assign ex_b  = fwd_b_em ? ex_mem_q.alu_out : (fwd_b_mw ? mem_wb_q.result : id_ex_q.b);
   assign alu_b = (id_ex_q.itype == RR_ALU) ? ex_b : id_ex_q.imm;

   pipe_mips32_alu u_alu (
      .op_i     (id_ex_q.op),
      .a_i      (ex_a),
      .b_i      (alu_b),
      .result_o (alu_res)
   );

   assign TAKEN_BRANCH = id_ex_q.valid && (id_ex_q.itype == BRANCH) &&
                         ((id_ex_q.op == OP_BEQZ) ? (ex_a == '0) : (ex_a != '0));
   assign ex_target    = id_ex_q.npc + id_ex_q.imm[PC_W-1:0];

   // ---------------- MEM / WB ----------------
   assign mem_rdata = Mem[ex_mem_q.alu_out[PC_W-1:0]];
   assign mem_we    = ex_mem_q.valid && (ex_mem_q.itype == STORE) && !HALTED;
   assign wb_we     = mem_wb_q.valid && writes_reg(mem_wb_q.itype) &&
                      (mem_wb_q.dest != 5'd0) && !HALTED;
   assign halted_d  = HALTED || (mem_wb_q.valid && (mem_wb_q.itype == HALT));

   always_comb begin
      pc_d         = PC;
      fetch_stop_d = fetch_stop_q;
      if_id_d      = if_id_q;

      id_ex_d.valid = if_id_q.valid;
      id_ex_d.itype = id_type;
      id_ex_d.op    = id_op;
      id_ex_d.rs    = id_rs;
      id_ex_d.rt    = id_rt;
      id_ex_d.dest  = (id_type == RR_ALU) ? id_rd : id_rt;
      id_ex_d.a     = id_a;
      id_ex_d.b     = id_b;
      id_ex_d.imm   = id_imm;
      id_ex_d.npc   = if_id_q.npc;

      ex_mem_d.valid   = id_ex_q.valid;
      ex_mem_d.itype   = id_ex_q.itype;
      ex_mem_d.dest    = id_ex_q.dest;
      ex_mem_d.alu_out = alu_res;
      ex_mem_d.b       = ex_b;

      mem_wb_d.valid  = ex_mem_q.valid;
      mem_wb_d.itype  = ex_mem_q.itype;
      mem_wb_d.dest   = ex_mem_q.dest;
      mem_wb_d.result = (ex_mem_q.itype == LOAD) ? mem_rdata : ex_mem_q.alu_out;

      // A taken branch outranks everything younger, including a HLT sitting in its shadow.
      if (TAKEN_BRANCH) begin
         pc_d          = ex_target;
         if_id_d.valid = 1'b0;
         id_ex_d.valid = 1'b0;
      end else if (load_use) begin
         id_ex_d.valid = 1'b0;
      end else if (id_is_hlt || fetch_stop_q) begin
         if_id_d.valid = 1'b0;
         fetch_stop_d  = 1'b1;
      end else begin
         if_id_d.valid = 1'b1;
         if_id_d.ir    = Mem[PC];
         if_id_d.npc   = pc_inc;
         pc_d          = pc_inc;
      end
   end

   always_ff @(posedge clock1 or negedge rst_n) begin
      if (!rst_n) begin
         PC           <= '0;
         HALTED       <= 1'b0;
         fetch_stop_q <= 1'b0;
         if_id_q      <= '0;
         id_ex_q      <= '0;
         ex_mem_q     <= '0;
         mem_wb_q     <= '0;
      end else begin
         PC           <= pc_d;
         HALTED       <= halted_d;
         fetch_stop_q <= fetch_stop_d;
         if_id_q      <= if_id_d;
         id_ex_q      <= id_ex_d;
         ex_mem_q     <= ex_mem_d;
         mem_wb_q     <= mem_wb_d;
      end
   end

   // Architectural storage keeps its contents across reset.
   always_ff @(posedge clock1) begin
      if (mem_we) Mem[ex_mem_q.alu_out[PC_W-1:0]] <= ex_mem_q.b;
      if (wb_we)  Reg[mem_wb_q.dest] <= mem_wb_q.result;
   end

endmodule

// File: tb/tb_pipe_mips32.sv
// Self-checking bench for pipe_mips32: preloads programs, runs to HLT, scoreboards Reg/Mem.
module tb_pipe_mips32;

   localparam logic [5:0] T_ADD   = 6'b000000;
   localparam logic [5:0] T_MUL   = 6'b000101;
   localparam logic [5:0] T_LW    = 6'b001000;
   localparam logic [5:0] T_SW    = 6'b001001;
   localparam logic [5:0] T_ADDI  = 6'b001010;
   localparam logic [5:0] T_SUBI  = 6'b001011;
   localparam logic [5:0] T_BNEQZ = 6'b001101;
   localparam logic [5:0] T_HLT   = 6'b111111;
   localparam int         MEMB    = 1000;

   logic clock1 = 1'b0;
   logic rst_n  = 1'b0;
   logic halted;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];
   int          loc_q[$];
   logic [31:0] prog_q[$];

   pipe_mips32 dut (
      .clock1 (clock1),
      .rst_n  (rst_n),
      .halted (halted)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clock1 = ~clock1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- encoders / driver tasks ----------------
   function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
      return {op, rs, rt, rd, 11'd0};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] peek(input int loc);
      if (loc >= MEMB) return dut.Mem[loc-MEMB];
      return dut.Reg[loc];
   endfunction

   task automatic push_exp(input int loc, input logic [31:0] val);
      loc_q.push_back(loc);
      exp_q.push_back(val);
   endtask

   // Hold reset, set Reg[k]=k, clear low memory and load prog_q at address 0.
   task automatic prep();
      rst_n = 1'b0;
      @(negedge clock1);
      for (int i = 0; i < 32; i++) dut.Reg[i] = 32'(i);
      for (int i = 0; i < 256; i++) dut.Mem[i] = '0;
      for (int i = 0; i < prog_q.size(); i++) dut.Mem[i] = prog_q[i];
   endtask

   task automatic release_reset();
      @(negedge clock1);
      rst_n = 1'b1;
   endtask

   // Counts clock edges after reset release until halted rises (-1 on timeout).
   task automatic run_to_halt(output int cyc, output int taken);
      cyc   = -1;
      taken = 0;
      for (int i = 1; i <= 3000; i++) begin
         @(posedge clock1);
         #1;
         if (dut.TAKEN_BRANCH) taken++;
         if (halted) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic build_fact_prog();
      prog_q = {};
      prog_q.push_back(enc_i(T_ADDI,  5'd0,  5'd10, 16'd200));
      prog_q.push_back(enc_i(T_LW,    5'd10, 5'd2,  16'd0));
      prog_q.push_back(enc_i(T_ADDI,  5'd0,  5'd3,  16'd1));
      prog_q.push_back(enc_r(T_MUL,   5'd3,  5'd2,  5'd3));
      prog_q.push_back(enc_i(T_SUBI,  5'd2,  5'd2,  16'd1));
      prog_q.push_back(enc_i(T_BNEQZ, 5'd2,  5'd0,  16'hFFFD));
      prog_q.push_back(enc_i(T_ADDI,  5'd21, 5'd21, 16'd1));
      prog_q.push_back(enc_i(T_ADDI,  5'd22, 5'd22, 16'd1));
      prog_q.push_back(enc_i(T_SW,    5'd10, 5'd3,  16'hFFFE));
      prog_q.push_back(enc_i(T_HLT,   5'd0,  5'd0,  16'd0));
   endtask

   task automatic push_fact_exp();
`ifdef MIPS32_MUL_EN
      push_exp(MEMB + 198, 32'd5040);
`else
      push_exp(MEMB + 198, 32'd1);
`endif
      push_exp(2, 32'd0);
      push_exp(21, 32'd1);
      push_exp(22, 32'd1);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clock1);
      #1;
      n_checks++;
      if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%b want=0", halted); end
      n_checks++;
      if (dut.PC !== '0) begin n_fail++; $display("FAIL reset_pc got=%0d want=0", dut.PC); end
      n_checks++;
      if (dut.TAKEN_BRANCH !== 1'b0) begin
         n_fail++; $display("FAIL reset_taken got=%b want=0", dut.TAKEN_BRANCH);
      end
   endtask

   task automatic test_basic_alu();
      int cyc, tk, loc;
      logic [31:0] e, a;
      prog_q = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                 32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
      prep();
      push_exp(0, 32'd0);  push_exp(1, 32'd10); push_exp(2, 32'd20); push_exp(3, 32'd25);
      push_exp(4, 32'd30); push_exp(5, 32'd55); push_exp(7, 32'd7);
      release_reset();
      run_to_halt(cyc, tk);
      n_checks++;
      if (cyc !== 13) begin n_fail++; $display("FAIL basic_cycles got=%0d want=13", cyc); end
      while (exp_q.size() > 0) begin
         loc = loc_q.pop_front(); e = exp_q.pop_front(); a = peek(loc);
         n_checks++;
         if (a !== e) begin n_fail++; $display("FAIL basic_result loc=%0d got=%0d want=%0d", loc, a, e); end
      end
      repeat (5) @(posedge clock1);
      #1;
      n_checks++;
      if (halted !== 1'b1) begin n_fail++; $display("FAIL basic_halt_stable got=%b want=1", halted); end
      n_checks++;
      if (dut.PC !== 10'd9) begin n_fail++; $display("FAIL basic_pc_frozen got=%0d want=9", dut.PC); end
   endtask

   task automatic test_back_to_back();
      int cyc, tk, loc;
      logic [31:0] e, a;
      prog_q = {};
      prog_q.push_back(enc_i(T_ADDI, 5'd0, 5'd1, 16'd10));
      prog_q.push_back(enc_r(T_ADD,  5'd1, 5'd1, 5'd2));
      prog_q.push_back(enc_r(T_ADD,  5'd2, 5'd1, 5'd3));
      prog_q.push_back(enc_i(T_HLT,  5'd0, 5'd0, 16'd0));
      prep();
      push_exp(1, 32'd10); push_exp(2, 32'd20); push_exp(3, 32'd30);
      release_reset();
      run_to_halt(cyc, tk);
      n_checks++;
      if (cyc !== 8) begin n_fail++; $display("FAIL b2b_cycles got=%0d want=8", cyc); end
      while (exp_q.size() > 0) begin
         loc = loc_q.pop_front(); e = exp_q.pop_front(); a = peek(loc);
         n_checks++;
         if (a !== e) begin n_fail++; $display("FAIL b2b_result loc=%0d got=%0d want=%0d", loc, a, e); end
      end
   endtask

   task automatic test_load_use();
      int cyc, tk, loc;
      logic [31:0] e, a;
      prog_q = {};
      prog_q.push_back(enc_i(T_ADDI, 5'd0, 5'd1, 16'd120));
      prog_q.push_back(enc_i(T_LW,   5'd1, 5'd2, 16'd0));
      prog_q.push_back(enc_i(T_ADDI, 5'd2, 5'd2, 16'd45));
      prog_q.push_back(enc_i(T_SW,   5'd1, 5'd2, 16'd1));
      prog_q.push_back(enc_i(T_HLT,  5'd0, 5'd0, 16'd0));
      prep();
      dut.Mem[120] = 32'd85;
      push_exp(MEMB + 121, 32'd130); push_exp(2, 32'd130);
      release_reset();
      run_to_halt(cyc, tk);
      n_checks++;
      if (cyc !== 10) begin n_fail++; $display("FAIL loaduse_cycles got=%0d want=10", cyc); end
      while (exp_q.size() > 0) begin
         loc = loc_q.pop_front(); e = exp_q.pop_front(); a = peek(loc);
         n_checks++;
         if (a !== e) begin n_fail++; $display("FAIL loaduse_result loc=%0d got=%0d want=%0d", loc, a, e); end
      end
   endtask

   task automatic test_branch_loop();
      int cyc, tk, loc;
      logic [31:0] e, a;
      build_fact_prog();
      prep();
      dut.Mem[200] = 32'd7;
      dut.Reg[21]  = '0;
      dut.Reg[22]  = '0;
      push_fact_exp();
      release_reset();
      run_to_halt(cyc, tk);
      n_checks++;
      if (cyc !== 44) begin n_fail++; $display("FAIL loop_cycles got=%0d want=44", cyc); end
      n_checks++;
      if (tk !== 6) begin n_fail++; $display("FAIL loop_taken got=%0d want=6", tk); end
      while (exp_q.size() > 0) begin
         loc = loc_q.pop_front(); e = exp_q.pop_front(); a = peek(loc);
         n_checks++;
         if (a !== e) begin n_fail++; $display("FAIL loop_result loc=%0d got=%0d want=%0d", loc, a, e); end
      end
   endtask

   task automatic test_r0_write();
      int cyc, tk, loc;
      logic [31:0] e, a;
      prog_q = {};
      prog_q.push_back(enc_i(T_ADDI, 5'd0, 5'd0, 16'd5));
      prog_q.push_back(enc_r(T_ADD,  5'd0, 5'd0, 5'd1));
      prog_q.push_back(enc_i(T_HLT,  5'd0, 5'd0, 16'd0));
      prep();
      dut.Reg[1] = 32'd77;
      push_exp(0, 32'd0); push_exp(1, 32'd0);
      release_reset();
      run_to_halt(cyc, tk);
      n_checks++;
      if (cyc !== 7) begin n_fail++; $display("FAIL r0_cycles got=%0d want=7", cyc); end
      while (exp_q.size() > 0) begin
         loc = loc_q.pop_front(); e = exp_q.pop_front(); a = peek(loc);
         n_checks++;
         if (a !== e) begin n_fail++; $display("FAIL r0_result loc=%0d got=%0d want=%0d", loc, a, e); end
      end
   endtask

   task automatic test_reset_midrun();
      int cyc, tk, loc;
      logic [31:0] e, a;
      build_fact_prog();
      prep();
      dut.Mem[200] = 32'd7;
      dut.Reg[21]  = '0;
      dut.Reg[22]  = '0;
      release_reset();
      repeat (15) @(posedge clock1);
      #3;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (halted !== 1'b0) begin n_fail++; $display("FAIL midrun_halted got=%b want=0", halted); end
      n_checks++;
      if (dut.PC !== '0) begin n_fail++; $display("FAIL midrun_pc got=%0d want=0", dut.PC); end
      n_checks++;
      if (dut.TAKEN_BRANCH !== 1'b0) begin
         n_fail++; $display("FAIL midrun_taken got=%b want=0", dut.TAKEN_BRANCH);
      end
      @(negedge clock1);
      push_fact_exp();
      release_reset();
      run_to_halt(cyc, tk);
      n_checks++;
      if (cyc !== 44) begin n_fail++; $display("FAIL midrun_cycles got=%0d want=44", cyc); end
      while (exp_q.size() > 0) begin
         loc = loc_q.pop_front(); e = exp_q.pop_front(); a = peek(loc);
         n_checks++;
         if (a !== e) begin n_fail++; $display("FAIL midrun_result loc=%0d got=%0d want=%0d", loc, a, e); end
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      test_reset();
      test_basic_alu();
      test_back_to_back();
      test_load_use();
      test_branch_loop();
      test_r0_write();
      test_reset_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
